// File: rtl/meter_pkg.sv
// Shared definitions for the parking-meter time counter.
// Holds the default BCD constants (add amounts, presets, low-time threshold),
// the state encoding and a helper that classifies a BCD time value.
package meter_pkg;

  localparam logic [15:0] ADD0_DEF       = 16'h0060;
  localparam logic [15:0] ADD1_DEF       = 16'h0120;
  localparam logic [15:0] ADD2_DEF       = 16'h0180;
  localparam logic [15:0] ADD3_DEF       = 16'h0300;
  localparam logic [15:0] PRESET0_DEF    = 16'h0015;
  localparam logic [15:0] PRESET1_DEF    = 16'h0150;
  localparam logic [15:0] LOW_THRESH_DEF = 16'h0180;
  localparam logic [15:0] BCD_MAX        = 16'h9999;

  typedef enum logic [1:0] {
    StExpired = 2'd0,
    StLow     = 2'd1,
    StRunning = 2'd2
  } meter_state_e;

  // Valid BCD orders the same way as binary, so a plain compare works here.
  function automatic meter_state_e state_of(input logic [15:0] t, input logic [15:0] thresh);
    if (t == 16'h0000) begin
      return StExpired;
    end else if (t < thresh) begin
      return StLow;
    end
    return StRunning;
  endfunction

endpackage

// File: rtl/bcd_digit_addsub.sv
// One BCD digit of an add/subtract ripple chain.
// Ports:
//   i_a, i_b : BCD operand digits (0-9)
//   i_cin    : carry-in (add) or borrow-in (subtract)
//   i_sub    : 1 = a - b - cin, 0 = a + b + cin
//   o_y      : BCD result digit (0-9)
//   o_cout   : carry-out (add) or borrow-out (subtract)
module bcd_digit_addsub (
  input  logic [3:0] i_a,
  input  logic [3:0] i_b,
  input  logic       i_cin,
  input  logic       i_sub,
  output logic [3:0] o_y,
  output logic       o_cout
);

  logic [4:0] w_sum;
  logic [4:0] w_dif;

  always_comb begin
    w_sum  = {1'b0, i_a} + {1'b0, i_b} + {4'd0, i_cin};
    w_dif  = {1'b0, i_a} - {1'b0, i_b} - {4'd0, i_cin};
    o_y    = 4'd0;
    o_cout = 1'b0;
    if (i_sub) begin
      // Negative result wraps in 4 bits; adding 10 restores the BCD digit.
      if (w_dif[4]) begin
        o_y    = w_dif[3:0] + 4'd10;
        o_cout = 1'b1;
      end else begin
        o_y = w_dif[3:0];
      end
    end else if (w_sum > 5'd9) begin
      o_y    = w_sum[3:0] + 4'd6;
      o_cout = 1'b1;
    end else begin
      o_y = w_sum[3:0];
    end
  end

endmodule

// File: rtl/meter_time_counter.sv
// Time-keeping core of the parking meter: remaining time as 4 BCD digits.
// Adds time on add pulses, loads presets, counts down on the 1 Hz tick.
// Ports:
//   i_clk          : system clock
//   i_rst          : synchronous active-high reset
//   i_tick_1hz     : one-cycle enable per second
//   i_add_pulse    : one-cycle add requests (lowest index wins)
//   i_preset_pulse : one-cycle preset loads (bit 0 wins)
//   o_digit3..0    : BCD thousands..ones (registered)
//   o_low_time     : 0 < time < LOW_THRESH (registered)
//   o_expired      : time == 0 (registered)
module meter_time_counter
  import meter_pkg::*;
#(
  parameter logic [15:0] ADD0       = ADD0_DEF,
  parameter logic [15:0] ADD1       = ADD1_DEF,
  parameter logic [15:0] ADD2       = ADD2_DEF,
  parameter logic [15:0] ADD3       = ADD3_DEF,
  parameter logic [15:0] PRESET0    = PRESET0_DEF,
  parameter logic [15:0] PRESET1    = PRESET1_DEF,
  parameter logic [15:0] LOW_THRESH = LOW_THRESH_DEF
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_tick_1hz,
  input  logic [3:0] i_add_pulse,
  input  logic [1:0] i_preset_pulse,
  output logic [3:0] o_digit3,
  output logic [3:0] o_digit2,
  output logic [3:0] o_digit1,
  output logic [3:0] o_digit0,
  output logic       o_low_time,
  output logic       o_expired
);

  logic [15:0]  r_time;
  meter_state_e r_state;
  logic         r_low_time;
  logic         r_expired;

  logic [15:0]  w_time_d;
  meter_state_e w_state_d;
  logic [15:0]  w_dec;
  logic [4:0]   w_dec_c;
  logic [15:0]  w_base;
  logic [15:0]  w_add_val;
  logic [15:0]  w_sum;
  logic [4:0]   w_add_c;
  logic         w_time_zero;

  // Decrement chain: borrow 1 into the ones digit.
  assign w_dec_c[0] = 1'b1;
  // Borrow out of the thousands digit only happens when time is 0000.
  assign w_time_zero = w_dec_c[4];

  // Add chain operand: decremented time when a tick rides along with the add.
  assign w_base     = (i_tick_1hz && !w_time_zero) ? w_dec : r_time;
  assign w_add_c[0] = 1'b0;

  always_comb begin
    w_add_val = ADD3;
    if (i_add_pulse[0]) begin
      w_add_val = ADD0;
    end else if (i_add_pulse[1]) begin
      w_add_val = ADD1;
    end else if (i_add_pulse[2]) begin
      w_add_val = ADD2;
    end
  end

  for (genvar g = 0; g < 4; g++) begin : g_chain
    bcd_digit_addsub u_dec (
      .i_a    (r_time[4*g +: 4]),
      .i_b    (4'd0),
      .i_cin  (w_dec_c[g]),
      .i_sub  (1'b1),
      .o_y    (w_dec[4*g +: 4]),
      .o_cout (w_dec_c[g+1])
    );
    bcd_digit_addsub u_add (
      .i_a    (w_base[4*g +: 4]),
      .i_b    (w_add_val[4*g +: 4]),
      .i_cin  (w_add_c[g]),
      .i_sub  (1'b0),
      .o_y    (w_sum[4*g +: 4]),
      .o_cout (w_add_c[g+1])
    );
  end

  // Next-state: priority preset > add > tick.
  always_comb begin
    w_time_d = r_time;
    if (i_preset_pulse[0]) begin
      w_time_d = PRESET0;
    end else if (i_preset_pulse[1]) begin
      w_time_d = PRESET1;
    end else if (|i_add_pulse) begin
      w_time_d = w_add_c[4] ? BCD_MAX : w_sum;
    end else if (i_tick_1hz && !w_time_zero) begin
      w_time_d = w_dec;
    end
    w_state_d = state_of(w_time_d, LOW_THRESH);
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_time     <= 16'h0000;
      r_state    <= StExpired;
      r_expired  <= 1'b1;
      r_low_time <= 1'b0;
    end else begin
      r_time     <= w_time_d;
      r_state    <= w_state_d;
      r_expired  <= (w_state_d == StExpired);
      r_low_time <= (w_state_d == StLow);
    end
  end

  assign o_digit3   = r_time[15:12];
  assign o_digit2   = r_time[11:8];
  assign o_digit1   = r_time[7:4];
  assign o_digit0   = r_time[3:0];
  assign o_low_time = r_low_time;
  assign o_expired  = r_expired;

  // r_state mirrors the flags; kept so the FSM is visible in waveforms.
  logic w_state_unused;
  assign w_state_unused = ^r_state;

endmodule

// File: tb/tb_meter_time_counter.sv
// Directed self-checking bench for meter_time_counter.
module tb_meter_time_counter;

  logic       clk = 1'b0;
  logic       rst;
  logic       tick;
  logic [3:0] add;
  logic [1:0] preset;
  logic [3:0] d3, d2, d1, d0;
  logic       low_time, expired;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  meter_time_counter dut (
    .i_clk          (clk),
    .i_rst          (rst),
    .i_tick_1hz     (tick),
    .i_add_pulse    (add),
    .i_preset_pulse (preset),
    .o_digit3       (d3),
    .o_digit2       (d2),
    .o_digit1       (d1),
    .o_digit0       (d0),
    .o_low_time     (low_time),
    .o_expired      (expired)
  );

  // One clock with the given inputs; outputs sampled 1 time unit after the edge.
  task automatic step(input logic t, input logic [3:0] a, input logic [1:0] p, input logic r);
    tick   = t;
    add    = a;
    preset = p;
    rst    = r;
    @(posedge clk);
    #1;
    tick   = 1'b0;
    add    = 4'd0;
    preset = 2'd0;
    rst    = 1'b0;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) step(1'b1, 4'd0, 2'd0, 1'b0);
  endtask

  task automatic check(input string tag, input logic [15:0] exp_time, input logic exp_low,
                       input logic exp_exp);
    logic [17:0] obs;
    logic [17:0] exp;
    obs = {d3, d2, d1, d0, low_time, expired};
    exp = {exp_time, exp_low, exp_exp};
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s: observed time=%h low=%b exp=%b, expected time=%h low=%b exp=%b",
             tag, obs[17:2], obs[1], obs[0], exp[17:2], exp[1], exp[0]);
    end
  endtask

  initial begin
    tick = 0; add = 0; preset = 0; rst = 1;
    @(posedge clk); #1;
    step(1'b0, 4'd0, 2'd0, 1'b1);
    check("reset", 16'h0000, 1'b0, 1'b1);
    ticks(5);
    check("hold_zero", 16'h0000, 1'b0, 1'b1);

    step(1'b0, 4'b0001, 2'd0, 1'b0);
    check("add0", 16'h0060, 1'b1, 1'b0);
    ticks(59);
    check("tick59", 16'h0001, 1'b1, 1'b0);
    ticks(1);
    check("tick60_expire", 16'h0000, 1'b0, 1'b1);

    step(1'b0, 4'd0, 2'b10, 1'b0);
    check("preset1", 16'h0150, 1'b1, 1'b0);
    step(1'b0, 4'b1000, 2'd0, 1'b0);
    check("add3_running", 16'h0450, 1'b0, 1'b0);
    ticks(1);
    check("tick_0449", 16'h0449, 1'b0, 1'b0);
    ticks(269);
    check("at_0180", 16'h0180, 1'b0, 1'b0);
    ticks(1);
    check("low_at_0179", 16'h0179, 1'b1, 1'b0);

    step(1'b0, 4'd0, 2'd0, 1'b1);
    for (int i = 0; i < 33; i++) step(1'b0, 4'b1000, 2'd0, 1'b0);
    check("load_9900", 16'h9900, 1'b0, 1'b0);
    step(1'b0, 4'b1000, 2'd0, 1'b0);
    check("saturate_9999", 16'h9999, 1'b0, 1'b0);
    ticks(1);
    check("tick_9998", 16'h9998, 1'b0, 1'b0);
    step(1'b1, 4'b1000, 2'b01, 1'b0);
    check("preset_wins", 16'h0015, 1'b1, 1'b0);
    step(1'b0, 4'd0, 2'b11, 1'b0);
    check("preset0_over_1", 16'h0015, 1'b1, 1'b0);

    step(1'b0, 4'd0, 2'b10, 1'b0);
    ticks(50);
    check("at_0100", 16'h0100, 1'b1, 1'b0);
    step(1'b1, 4'b0010, 2'd0, 1'b0);
    check("add1_tick", 16'h0219, 1'b0, 1'b0);
    step(1'b0, 4'd0, 2'd0, 1'b1);
    step(1'b1, 4'b0010, 2'd0, 1'b0);
    check("add1_tick_zero", 16'h0120, 1'b1, 1'b0);

    step(1'b0, 4'd0, 2'd0, 1'b1);
    for (int i = 0; i < 3; i++) step(1'b0, 4'b1000, 2'd0, 1'b0);
    step(1'b0, 4'b0010, 2'd0, 1'b0);
    check("at_1020", 16'h1020, 1'b0, 1'b0);
    ticks(20);
    check("at_1000", 16'h1000, 1'b0, 1'b0);
    ticks(1);
    check("borrow_0999", 16'h0999, 1'b0, 1'b0);
    step(1'b0, 4'b1010, 2'd0, 1'b0);
    check("lowest_add", 16'h1119, 1'b0, 1'b0);
    step(1'b1, 4'b0100, 2'b01, 1'b1);
    check("rst_priority", 16'h0000, 1'b0, 1'b1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
